mux_demux_fifo: RTL and testbench

//  1-to-2 routing buffer; the opposite direction of our 2:1 32-bit selector mux.
//  - One upstream valid/ready channel carries a 32-bit word and a select bit S.
//  - Each word goes into one of two downstream per-port FIFOs: S=0 -> port 0 (I1 side), S=1 -> port 1 (I2 side).
//  - Sits between a shared result/response bus and two consumers (e.g. fetch and data path) that drain at independent rates.

---
 rtl/mux_demux_fifo_if.sv | 29 ++
 rtl/mux_demux_fifo.sv | 92 +++++++++
 tb/tb_mux_demux_fifo.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mux_demux_fifo_if.sv
// Upstream word channel plus two downstream per-port FIFO heads with occupancy.
// slave: the routing buffer; master: the producer and both consumers.
interface mux_demux_fifo_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 1
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic [AW:0]      out0_count;
  logic [AW:0]      out1_count;

  modport slave (
    input  in_valid, in_data, in_sel, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data, out0_count, out1_count
  );

  modport master (
    output in_valid, in_data, in_sel, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data, out0_count, out1_count
  );
endinterface

// File: rtl/mux_demux_fifo.sv
// 1-to-2 routing buffer: each upstream word lands in the FIFO picked by in_sel; 1-cycle latency, no bypass.
// Backpressure: in_ready drops when the selected port is full, regardless of that port's pop this cycle.
module mux_demux_fifo_port #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Full/empty come from count only; pointer equality is ambiguous at DEPTH entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
endmodule

module mux_demux_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input logic             clk,
  input logic             rst_n,
  mux_demux_fifo_if.slave bus
);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic push0;
  logic push1;
  logic pop0;
  logic pop1;

  assign bus.in_ready   = bus.in_sel ? (bus.out1_count != FULL) : (bus.out0_count != FULL);
  assign bus.out0_valid = (bus.out0_count != '0);
  assign bus.out1_valid = (bus.out1_count != '0);

  assign push0 = bus.in_valid & bus.in_ready & ~bus.in_sel;
  assign push1 = bus.in_valid & bus.in_ready &  bus.in_sel;
  assign pop0  = bus.out0_valid & bus.out0_ready;
  assign pop1  = bus.out1_valid & bus.out1_ready;

  mux_demux_fifo_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_port0 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push0),
    .wdata (bus.in_data),
    .pop   (pop0),
    .rdata (bus.out0_data),
    .count (bus.out0_count)
  );

  mux_demux_fifo_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_port1 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push1),
    .wdata (bus.in_data),
    .pop   (pop1),
    .rdata (bus.out1_data),
    .count (bus.out1_count)
  );
endmodule

// File: tb/tb_mux_demux_fifo.sv
// Directed and random traffic against a queue-based per-port model, plus hand-computed literal checks.
module tb_mux_demux_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int AW    = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_demux_fifo_if #(.WIDTH(WIDTH), .AW(AW)) bus ();
  mux_demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare against the model at negedge, advance the model at posedge, return 1 after it.
  task automatic step();
    bit do_push, do_pop0, do_pop1, sel, rdy;
    logic [WIDTH-1:0] d;
    @(negedge clk);
    do_push = 0; do_pop0 = 0; do_pop1 = 0;
    sel = bus.in_sel;
    d   = bus.in_data;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      rdy = (sel ? q1.size() : q0.size()) != DEPTH;
      check("m_out0_valid", WIDTH'(bus.out0_valid), WIDTH'(q0.size() != 0));
      check("m_out1_valid", WIDTH'(bus.out1_valid), WIDTH'(q1.size() != 0));
      check("m_out0_count", WIDTH'(bus.out0_count), WIDTH'(q0.size()));
      check("m_out1_count", WIDTH'(bus.out1_count), WIDTH'(q1.size()));
      check("m_in_ready", WIDTH'(bus.in_ready), WIDTH'(rdy));
      if (q0.size() != 0) check("m_out0_data", bus.out0_data, q0[0]);
      if (q1.size() != 0) check("m_out1_data", bus.out1_data, q1[0]);
      do_push = bus.in_valid && rdy;
      do_pop0 = bus.out0_ready && q0.size() != 0;
      do_pop1 = bus.out1_ready && q1.size() != 0;
    end
    @(posedge clk);
    if (rst_n) begin
      if (do_pop0) void'(q0.pop_front());
      if (do_pop1) void'(q1.pop_front());
      if (do_push) begin
        if (sel) q1.push_back(d);
        else     q0.push_back(d);
      end
    end
    #1;
  endtask

  task automatic drive(input bit v, input bit s, input logic [WIDTH-1:0] d);
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_data  = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(0, 0, '0);
    bus.out0_ready = 0;
    bus.out1_ready = 0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // T1: reset in the middle of traffic
    drive(1, 0, 32'h1111_0001); step();
    drive(1, 1, 32'h2222_0002); step();
    drive(1, 0, 32'h1111_0003);
    rst_n = 1'b0;
    #1;
    check("t1_out0_valid", WIDTH'(bus.out0_valid), 0);
    check("t1_out1_valid", WIDTH'(bus.out1_valid), 0);
    check("t1_out0_count", WIDTH'(bus.out0_count), 0);
    check("t1_out1_count", WIDTH'(bus.out1_count), 0);
    drive(0, 0, '0);
    step();
    rst_n = 1'b1;
    #1;
    check("t1_in_ready_sel0", WIDTH'(bus.in_ready), 1);
    bus.in_sel = 1; #1;
    check("t1_in_ready_sel1", WIDTH'(bus.in_ready), 1);
    step();

    // T2: routing
    drive(1, 0, 32'hA000_0001); step();
    drive(1, 1, 32'hB000_0002); step();
    drive(1, 0, 32'hA000_0003); step();
    drive(0, 0, '0);
    check("t2_out0_count", WIDTH'(bus.out0_count), 2);
    check("t2_out1_count", WIDTH'(bus.out1_count), 1);
    check("t2_out0_data", bus.out0_data, 32'hA000_0001);
    check("t2_out1_data", bus.out1_data, 32'hB000_0002);
    bus.out0_ready = 1; bus.out1_ready = 1;
    repeat (3) step();
    check("t2_drained", WIDTH'(bus.out0_count + bus.out1_count), 0);
    bus.out0_ready = 0; bus.out1_ready = 0;

    // T3: full port blocks, other port still accepted, request retargets
    drive(1, 0, 32'hD000_0001); step();
    drive(1, 0, 32'hD000_0002); step();
    drive(1, 0, 32'hD000_0003); #1;
    check("t3_in_ready_full", WIDTH'(bus.in_ready), 0);
    step();
    check("t3_count0_held", WIDTH'(bus.out0_count), 2);
    drive(1, 1, 32'hC000_0004); #1;
    check("t3_in_ready_sel1", WIDTH'(bus.in_ready), 1);
    step();
    check("t3_out1_count", WIDTH'(bus.out1_count), 1);
    check("t3_out1_data", bus.out1_data, 32'hC000_0004);

    // T4: full port pops while a push waits; push lands next cycle
    drive(1, 0, 32'hD000_0003);
    bus.out0_ready = 1; #1;
    check("t4_in_ready", WIDTH'(bus.in_ready), 0);
    step();
    check("t4_count0_pop", WIDTH'(bus.out0_count), 1);
    check("t4_out0_head", bus.out0_data, 32'hD000_0002);
    check("t4_in_ready_after", WIDTH'(bus.in_ready), 1);
    step();
    check("t4_count0_pushpop", WIDTH'(bus.out0_count), 1);
    check("t4_out0_head2", bus.out0_data, 32'hD000_0003);
    drive(0, 0, '0);
    bus.out1_ready = 1;
    repeat (2) step();
    bus.out1_ready = 0;

    // T5: streaming with wrap
    bus.out0_ready = 1;
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, WIDTH'(i));
      step();
      check("t5_count0", WIDTH'(bus.out0_count), 1);
      check("t5_out0_data", bus.out0_data, WIDTH'(i));
    end
    drive(0, 0, '0);
    step();
    check("t5_empty", WIDTH'(bus.out0_count), 0);

    // T6: random traffic
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), WIDTH'($urandom));
      bus.out0_ready = 1'($urandom_range(0, 1));
      bus.out1_ready = 1'($urandom_range(0, 1));
      step();
    end
    drive(0, 0, '0);
    bus.out0_ready = 1; bus.out1_ready = 1;
    repeat (DEPTH + 2) step();
    check("t6_final_count0", WIDTH'(bus.out0_count), 0);
    check("t6_final_count1", WIDTH'(bus.out1_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
